// File: rtl/bus_pkg.sv
// Shared types for the two-master / three-slave bus demonstrator:
// widths, bus op codes, master FSM states, scenario ROM, slave decode.
package bus_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WR,
        OP_RD
    } op_t;

    typedef enum logic [2:0] {
        M_IDLE,
        M_REQ,
        M_ADDR,
        M_DATA,
        M_REL
    } mst_state_t;

    typedef struct packed {
        op_t               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    typedef struct packed {
        txn_t m1;
        txn_t m2;
    } scen_t;

    // Fixed transaction pair for each scenario code; unlisted codes are empty.
    function automatic scen_t scenario_rom(input logic [4:0] code);
        scen_t s;
        s = '0;
        case (code)
            5'd1: s.m1 = '{OP_WR, 14'd1001, 8'd101};
            5'd2: s.m2 = '{OP_WR, 14'd5097, 8'd102};
            5'd3: begin
                s.m1 = '{OP_RD, 14'd5097, 8'd0};
                s.m2 = '{OP_RD, 14'd1001, 8'd0};
            end
            5'd7: begin
                s.m1 = '{OP_WR, 14'd5097, 8'd103};
                s.m2 = '{OP_WR, 14'd5098, 8'd104};
            end
            5'd8: begin
                s.m1 = '{OP_RD, 14'd5097, 8'd0};
                s.m2 = '{OP_RD, 14'd5098, 8'd0};
            end
            5'd9: begin
                s.m1 = '{OP_WR, 14'd5099, 8'd105};
                s.m2 = '{OP_WR, 14'd1002, 8'd106};
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    // One-hot select from addr[13:12]: bits 0..2 are S1..S3, bit 3 unmapped.
    function automatic logic [3:0] slave_dec(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/bus_master.sv
// Bus master: runs one latched transaction REQ -> ADDR -> DATA -> RELEASE.
// Ports: launch/txn in, gnt/rvalid/rdata_bus from bus, req/rel and bus drive out, rdata = last read.
module bus_master
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              launch,
    input  txn_t              txn,
    input  logic              gnt,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata_bus,
    output logic              req,
    output logic              rel,
    output logic              avalid,
    output logic              we,
    output logic              wvalid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    mst_state_t state, state_nx;
    txn_t       cur;
    logic       is_wr;

    assign is_wr = (cur.op == OP_WR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= M_IDLE;
            cur   <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (launch && state == M_IDLE)
                cur <= txn;
            if (state == M_DATA && !is_wr && rvalid)
                rdata <= rdata_bus;
        end
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        rel      = 1'b0;
        avalid   = 1'b0;
        we       = 1'b0;
        wvalid   = 1'b0;
        addr     = '0;
        wdata    = '0;
        case (state)
            M_IDLE: if (launch) state_nx = M_REQ;
            M_REQ: begin
                req = 1'b1;
                if (gnt) state_nx = M_ADDR;
            end
            M_ADDR: begin
                avalid   = 1'b1;
                we       = is_wr;
                addr     = cur.addr;
                state_nx = M_DATA;
            end
            M_DATA: begin
                // Address stays up so the slave select holds for the write beat.
                we     = is_wr;
                addr   = cur.addr;
                wvalid = is_wr;
                wdata  = is_wr ? cur.data : '0;
                if (is_wr || rvalid) state_nx = M_REL;
            end
            M_REL: begin
                rel      = 1'b1;
                state_nx = M_IDLE;
            end
            default: state_nx = M_IDLE;
        endcase
    end

endmodule

// File: rtl/bus_slave_mem.sv
// Memory-backed slave: writes on the data beat, returns read data RD_LATENCY cycles after address.
// Ports: sel/avalid/we/wvalid/addr/wdata from bus, rvalid/rdata back (zero when not valid).
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int RD_LATENCY = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              avalid,
    input  logic              we,
    input  logic              wvalid,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rd_q;
    logic [RD_LATENCY-1:0] pipe;
    logic                  rd_acc;

    assign rd_acc = sel && avalid && !we;

    // Contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (sel && wvalid)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
            pipe <= '0;
        end else begin
            if (rd_acc)
                rd_q <= mem[addr];
            pipe[0] <= rd_acc;
            for (int i = 1; i < RD_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign rvalid = pipe[RD_LATENCY-1];
    assign rdata  = rvalid ? rd_q : '0;

endmodule

// File: rtl/bus_top_level.sv
// Shared-bus demonstrator top: scenario sequencer, M1-priority arbiter, address decode, 2 masters, 3 slaves.
// Ports: clk, reset, start, state_in in; busy, done, m1_rdata, m2_rdata, bus_owner out.
module bus_top_level
    import bus_pkg::*;
#(
    parameter int SLAVE_DEPTH = 4096,
    parameter int RD_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        state_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [DATA_W-1:0] m2_rdata,
    output logic [1:0]        bus_owner
);

    localparam int SAW = $clog2(SLAVE_DEPTH);

    logic  start_q, start_edge, pend1, pend2;
    scen_t scen_now;
    logic  m1_req, m1_rel, m1_av, m1_we, m1_wv;
    logic  m2_req, m2_rel, m2_av, m2_we, m2_wv;
    logic  [ADDR_W-1:0] m1_addr, m2_addr, b_addr;
    logic  [DATA_W-1:0] m1_wd, m2_wd, b_wd, b_rd;
    logic  b_av, b_we, b_wv, b_rv;
    logic  [1:0] owner, owner_nx;
    logic  [3:0] dec;
    logic  [2:0] s_rv;
    logic  [DATA_W-1:0] s_rd [3];
    logic  [RD_LATENCY-1:0] um_pipe;

    // Sequencer
    assign start_edge = start && !start_q && !busy;
    assign scen_now   = scenario_rom(state_in);
    assign done       = busy && (!pend1 || m1_rel) && (!pend2 || m2_rel);

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            busy    <= 1'b0;
            pend1   <= 1'b0;
            pend2   <= 1'b0;
        end else begin
            start_q <= start;
            if (m1_rel) pend1 <= 1'b0;
            if (m2_rel) pend2 <= 1'b0;
            if (start_edge) begin
                busy  <= 1'b1;
                pend1 <= (scen_now.m1.op != OP_NONE);
                pend2 <= (scen_now.m2.op != OP_NONE);
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

    // Arbiter: grant held until the owner's RELEASE, handed straight to a waiter.
    always_comb begin
        owner_nx = owner;
        case (owner)
            2'd0: begin
                if (m1_req)      owner_nx = 2'd1;
                else if (m2_req) owner_nx = 2'd2;
            end
            2'd1: if (m1_rel) owner_nx = m2_req ? 2'd2 : 2'd0;
            2'd2: if (m2_rel) owner_nx = m1_req ? 2'd1 : 2'd0;
            default: owner_nx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) owner <= 2'd0;
        else       owner <= owner_nx;
    end

    assign bus_owner = owner;

    // Bus mux: idle bus is all zeros.
    always_comb begin
        b_av   = 1'b0;
        b_we   = 1'b0;
        b_wv   = 1'b0;
        b_addr = '0;
        b_wd   = '0;
        case (owner)
            2'd1: begin
                b_av = m1_av; b_we = m1_we; b_wv = m1_wv;
                b_addr = m1_addr; b_wd = m1_wd;
            end
            2'd2: begin
                b_av = m2_av; b_we = m2_we; b_wv = m2_wv;
                b_addr = m2_addr; b_wd = m2_wd;
            end
            default: ;
        endcase
    end

    assign dec = slave_dec(b_addr[ADDR_W-1 -: 2]);

    // Unmapped reads answer with zero data after the normal latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            um_pipe <= '0;
        end else begin
            um_pipe[0] <= b_av && !b_we && dec[3];
            for (int i = 1; i < RD_LATENCY; i++)
                um_pipe[i] <= um_pipe[i-1];
        end
    end

    assign b_rv = (|s_rv) || um_pipe[RD_LATENCY-1];
    assign b_rd = s_rd[0] | s_rd[1] | s_rd[2];

    bus_master u_m1 (
        .clk(clk), .reset(reset),
        .launch(start_edge && scen_now.m1.op != OP_NONE),
        .txn(scen_now.m1), .gnt(owner == 2'd1),
        .rvalid(b_rv && owner == 2'd1), .rdata_bus(b_rd),
        .req(m1_req), .rel(m1_rel), .avalid(m1_av), .we(m1_we),
        .wvalid(m1_wv), .addr(m1_addr), .wdata(m1_wd), .rdata(m1_rdata)
    );

    bus_master u_m2 (
        .clk(clk), .reset(reset),
        .launch(start_edge && scen_now.m2.op != OP_NONE),
        .txn(scen_now.m2), .gnt(owner == 2'd2),
        .rvalid(b_rv && owner == 2'd2), .rdata_bus(b_rd),
        .req(m2_req), .rel(m2_rel), .avalid(m2_av), .we(m2_we),
        .wvalid(m2_wv), .addr(m2_addr), .wdata(m2_wd), .rdata(m2_rdata)
    );

    bus_slave_mem #(.DEPTH(SLAVE_DEPTH), .RD_LATENCY(RD_LATENCY)) u_s1 (
        .clk(clk), .reset(reset), .sel(dec[0]), .avalid(b_av), .we(b_we),
        .wvalid(b_wv), .addr(b_addr[SAW-1:0]), .wdata(b_wd),
        .rvalid(s_rv[0]), .rdata(s_rd[0])
    );

    bus_slave_mem #(.DEPTH(SLAVE_DEPTH), .RD_LATENCY(RD_LATENCY)) u_s2 (
        .clk(clk), .reset(reset), .sel(dec[1]), .avalid(b_av), .we(b_we),
        .wvalid(b_wv), .addr(b_addr[SAW-1:0]), .wdata(b_wd),
        .rvalid(s_rv[1]), .rdata(s_rd[1])
    );

    bus_slave_mem #(.DEPTH(SLAVE_DEPTH), .RD_LATENCY(RD_LATENCY)) u_s3 (
        .clk(clk), .reset(reset), .sel(dec[2]), .avalid(b_av), .we(b_we),
        .wvalid(b_wv), .addr(b_addr[SAW-1:0]), .wdata(b_wd),
        .rvalid(s_rv[2]), .rdata(s_rd[2])
    );

endmodule

// File: tb/tb_bus_top_level.sv
// Self-checking bench for bus_top_level: scenario table with scoreboard,
// plus hand sequences for reset, held start, start during busy and mid-scenario reset.
module tb_bus_top_level;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] state_in;
    logic       busy, done;
    logic [7:0] m1_rdata, m2_rdata;
    logic [1:0] bus_owner;

    localparam int WIN = 20;

    typedef struct {
        logic [4:0] code;
        int         lat;
        logic [7:0] m1;
        logic [7:0] m2;
        logic [1:0] own_first;
        logic [1:0] own_last;
        int         hold;
        bit         glitch;
    } vec_t;

    vec_t tab [7];
    vec_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_top_level dut (
        .clk(clk), .reset(reset), .start(start), .state_in(state_in),
        .busy(busy), .done(done), .m1_rdata(m1_rdata), .m2_rdata(m2_rdata),
        .bus_owner(bus_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        vec_t       e;
        int         lat, ndone, berr;
        logic [1:0] of, ol;
        logic       exp_busy;
        string      tag;
        sb.push_back(v);
        lat = -1; ndone = 0; berr = 0; of = 2'd0; ol = 2'd0;
        @(negedge clk);
        state_in = v.code;
        start    = 1'b1;
        for (int k = 1; k <= WIN; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (bus_owner != 2'd0) begin
                if (of == 2'd0) of = bus_owner;
                ol = bus_owner;
            end
            exp_busy = (lat < 0) || (k <= lat);
            if (busy !== exp_busy) berr++;
            if (k == v.hold) start = 1'b0;
            if (v.glitch) begin
                if (k == 4) begin start = 1'b1; state_in = 5'd1; end
                if (k == 5) start = 1'b0;
            end
        end
        e   = sb.pop_front();
        tag = $sformatf("code%0d", e.code);
        chk({tag, "_latency"},   lat,   e.lat);
        chk({tag, "_done_cnt"},  ndone, 1);
        chk({tag, "_busy_errs"}, berr,  0);
        chk({tag, "_m1_rdata"},  m1_rdata, e.m1);
        chk({tag, "_m2_rdata"},  m2_rdata, e.m2);
        chk({tag, "_own_first"}, of, e.own_first);
        chk({tag, "_own_last"},  ol, e.own_last);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_m1_rdata"},  m1_rdata,  0);
        chk({tag, "_m2_rdata"},  m2_rdata,  0);
        chk({tag, "_bus_owner"}, bus_owner, 0);
    endtask

    initial begin
        tab[0] = '{code:5'd0, lat:1,  m1:8'd0,   m2:8'd0,   own_first:2'd0, own_last:2'd0, hold:1, glitch:1'b0};
        tab[1] = '{code:5'd1, lat:5,  m1:8'd0,   m2:8'd0,   own_first:2'd1, own_last:2'd1, hold:1, glitch:1'b0};
        tab[2] = '{code:5'd2, lat:5,  m1:8'd0,   m2:8'd0,   own_first:2'd2, own_last:2'd2, hold:1, glitch:1'b0};
        tab[3] = '{code:5'd3, lat:11, m1:8'd102, m2:8'd101, own_first:2'd1, own_last:2'd2, hold:1, glitch:1'b0};
        tab[4] = '{code:5'd7, lat:9,  m1:8'd102, m2:8'd101, own_first:2'd1, own_last:2'd2, hold:1, glitch:1'b0};
        tab[5] = '{code:5'd8, lat:11, m1:8'd103, m2:8'd104, own_first:2'd1, own_last:2'd2, hold:1, glitch:1'b0};
        tab[6] = '{code:5'd4, lat:1,  m1:8'd103, m2:8'd104, own_first:2'd0, own_last:2'd0, hold:1, glitch:1'b0};

        reset = 1'b1; start = 1'b0; state_in = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(tab[i]);
            if (tab[i].code == 5'd2) begin
                chk("peek_s1_1001", dut.u_s1.mem[1001], 101);
                chk("peek_s2_1001", dut.u_s2.mem[1001], 102);
            end
        end

        // start held for two cycles: one execution only
        run('{code:5'd1, lat:5, m1:8'd103, m2:8'd104,
              own_first:2'd1, own_last:2'd1, hold:2, glitch:1'b0});

        // new start edge during busy is ignored
        run('{code:5'd3, lat:11, m1:8'd103, m2:8'd101,
              own_first:2'd1, own_last:2'd2, hold:1, glitch:1'b1});

        // reset in the middle of scenario 9
        @(negedge clk);
        state_in = 5'd9;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid9_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid9_reset");
        reset = 1'b0;

        run('{code:5'd1, lat:5, m1:8'd0, m2:8'd0,
              own_first:2'd1, own_last:2'd1, hold:1, glitch:1'b0});
        chk("keep_s1_1001", dut.u_s1.mem[1001], 101);
        chk("keep_s2_1001", dut.u_s2.mem[1001], 103);
        chk("keep_s2_1002", dut.u_s2.mem[1002], 104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
